data_mem_responder: RTL and testbench

Responder end of the core's data-memory port: accepts the core's word address, byte mask, write data and mode, and returns read data one cycle later on the core's `data_in`. Holds a parameterised on-chip RAM, a small MMIO timer block and a secondary debug/DMA port that is arbitrated below the core and blocked by `bus_lock`. Sits beside the core at top level, in place of a plain data RAM.

---
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: RAM, MMIO timer and a secondary debug port that the core always wins over.
// Define DATA_MEM_TIMER_EN to build the mtime/mtimecmp timer; otherwise the MMIO words are unmapped.
module data_mem_responder #(
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        bus_lock,
  input  logic        memory_mode,
  input  logic [29:0] data_address,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [29:0] dbg_addr,
  input  logic [3:0]  dbg_mask,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic        coreAccess;
  logic        accWe;
  logic        accWrite;
  logic [29:0] accAddr;
  logic [3:0]  accMask;
  logic [31:0] accWdata;
  logic        ramSel;
  logic [AW-1:0] ramIdx;
  logic [31:0] rdWord;

  logic        lock_q;
  logic [31:0] dataIn_q;
  logic [31:0] dbgRdata_q;
  logic        dbgRvalid_q;

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = oldWord;
    for (int b = 0; b < 4; b++)
      if (mask[b]) res[8*b +: 8] = newWord[8*b +: 8];
    return res;
  endfunction

  // The core always wins; the debug port is also shut out while the core holds the lock.
  assign coreAccess = clk_en & (|data_mask);
  assign dbg_gnt    = dbg_req & clk_en & ~coreAccess & ~bus_lock & ~lock_q;

  assign accAddr  = coreAccess ? data_address : dbg_addr;
  assign accMask  = coreAccess ? data_mask    : dbg_mask;
  assign accWdata = coreAccess ? data_out     : dbg_wdata;
  assign accWe    = coreAccess ? memory_mode  : dbg_we;
  assign accWrite = (coreAccess | dbg_gnt) & accWe;

  assign ramSel = (accAddr[29:AW] == '0);
  assign ramIdx = accAddr[AW-1:0];

  always_ff @(posedge clk) begin
    if (accWrite && ramSel) begin
      for (int b = 0; b < 4; b++)
        if (accMask[b]) mem[ramIdx][8*b +: 8] <= accWdata[8*b +: 8];
    end
  end

`ifdef DATA_MEM_TIMER_EN
  logic        mmioSel;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q;

  assign mmioSel = &accAddr[29:2];

  // A write to either mtime half replaces the increment for the whole 64-bit value.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (accWrite && mmioSel) begin
      case (accAddr[1:0])
        2'd0: mtime_d = {mtime_q[63:32], mergeLanes(mtime_q[31:0], accWdata, accMask)};
        2'd1: mtime_d = {mergeLanes(mtime_q[63:32], accWdata, accMask), mtime_q[31:0]};
        2'd2: mtimecmp_d = {mtimecmp_q[63:32], mergeLanes(mtimecmp_q[31:0], accWdata, accMask)};
        default: mtimecmp_d = {mergeLanes(mtimecmp_q[63:32], accWdata, accMask), mtimecmp_q[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else if (clk_en) begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  always_comb begin
    rdWord = '0;
    if (ramSel) begin
      rdWord = mem[ramIdx];
    end else if (mmioSel) begin
      case (accAddr[1:0])
        2'd0:    rdWord = mtime_q[31:0];
        2'd1:    rdWord = mtime_q[63:32];
        2'd2:    rdWord = mtimecmp_q[31:0];
        default: rdWord = mtimecmp_q[63:32];
      endcase
    end
  end

  assign timer_irq = irq_q;
`else
  always_comb begin
    rdWord = '0;
    if (ramSel) rdWord = mem[ramIdx];
  end

  assign timer_irq = 1'b0;
`endif

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      lock_q      <= 1'b0;
      dataIn_q    <= '0;
      dbgRdata_q  <= '0;
      dbgRvalid_q <= 1'b0;
    end else if (clk_en) begin
      if (coreAccess) lock_q <= bus_lock;
      if (coreAccess && !memory_mode) dataIn_q <= rdWord;
      if (dbg_gnt && !dbg_we) dbgRdata_q <= rdWord;
      dbgRvalid_q <= dbg_gnt & ~dbg_we;
    end
  end

  assign data_in    = dataIn_q;
  assign dbg_rdata  = dbgRdata_q;
  assign dbg_rvalid = dbgRvalid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; timer checks run only when DATA_MEM_TIMER_EN is defined.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        bus_lock;
  logic        memory_mode;
  logic [29:0] data_address;
  logic [3:0]  data_mask;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        dbg_req;
  logic        dbg_we;
  logic [29:0] dbg_addr;
  logic [3:0]  dbg_mask;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(4096), .INIT_FILE("")) dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
    .bus_lock     (bus_lock),
    .memory_mode  (memory_mode),
    .data_address (data_address),
    .data_mask    (data_mask),
    .data_out     (data_out),
    .data_in      (data_in),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_mask     (dbg_mask),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .timer_irq    (timer_irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic we, input logic [29:0] addr,
                               input logic [3:0] mask, input logic [31:0] wdata);
    bus_lock     = lock;
    memory_mode  = we;
    data_address = addr;
    data_mask    = mask;
    data_out     = wdata;
  endtask

  task automatic driveDbg(input logic req, input logic we, input logic [29:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_mask  = mask;
    dbg_wdata = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coreOp(input logic we, input logic [29:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata);
    applyStimulus(1'b0, we, addr, mask, wdata);
    step();
    applyStimulus(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    applyStimulus(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    driveDbg(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    #12;
    checkOutput("rst_data_in", data_in, 32'd0);
    checkOutput("rst_dbg_rdata", dbg_rdata, 32'd0);
    checkOutput("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    checkOutput("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    step();

    // Full-word write then read.
    coreOp(1'b1, 30'd5, 4'hF, 32'hDEADBEEF);
    coreOp(1'b0, 30'd5, 4'hF, 32'd0);
    checkOutput("rd_full", data_in, 32'hDEADBEEF);

    // Single-lane write merges into the existing word.
    coreOp(1'b1, 30'd6, 4'hF, 32'h11223344);
    coreOp(1'b1, 30'd6, 4'b0010, 32'h0000AA00);
    coreOp(1'b0, 30'd6, 4'h1, 32'd0);
    checkOutput("rd_lane", data_in, 32'h1122AA44);
    step();
    step();
    checkOutput("rd_hold", data_in, 32'h1122AA44);

    // Clock enable low freezes the read register.
    clk_en = 1'b0;
    coreOp(1'b0, 30'd5, 4'hF, 32'd0);
    clk_en = 1'b1;
    checkOutput("clken_data_in", data_in, 32'h1122AA44);

    // Core wins arbitration; the debug read is granted once the core is idle.
    applyStimulus(1'b0, 1'b0, 30'd5, 4'hF, 32'd0);
    driveDbg(1'b1, 1'b0, 30'd6, 4'hF, 32'd0);
    #1;
    checkOutput("arb_gnt_busy", {31'd0, dbg_gnt}, 32'd0);
    step();
    checkOutput("arb_rvalid_busy", {31'd0, dbg_rvalid}, 32'd0);
    checkOutput("arb_core_rd", data_in, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    #1;
    checkOutput("arb_gnt_idle", {31'd0, dbg_gnt}, 32'd1);
    step();
    driveDbg(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    checkOutput("dbg_rvalid_pulse", {31'd0, dbg_rvalid}, 32'd1);
    checkOutput("dbg_rdata", dbg_rdata, 32'h1122AA44);
    step();
    checkOutput("dbg_rvalid_drop", {31'd0, dbg_rvalid}, 32'd0);

    // Debug write lands in RAM and gives no response.
    driveDbg(1'b1, 1'b1, 30'd7, 4'hF, 32'hCAFEF00D);
    #1;
    checkOutput("dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
    step();
    driveDbg(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    checkOutput("dbg_wr_norsp", {31'd0, dbg_rvalid}, 32'd0);
    coreOp(1'b0, 30'd7, 4'hF, 32'd0);
    checkOutput("dbg_wr_data", data_in, 32'hCAFEF00D);

    // dbg_rvalid and data_in both hold while clk_en is low.
    driveDbg(1'b1, 1'b0, 30'd5, 4'hF, 32'd0);
    step();
    driveDbg(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    checkOutput("hold_rvalid_set", {31'd0, dbg_rvalid}, 32'd1);
    checkOutput("hold_rdata", dbg_rdata, 32'hDEADBEEF);
    clk_en = 1'b0;
    coreOp(1'b0, 30'd6, 4'hF, 32'd0);
    checkOutput("hold_rvalid_clken", {31'd0, dbg_rvalid}, 32'd1);
    checkOutput("hold_data_in_clken", data_in, 32'hCAFEF00D);
    clk_en = 1'b1;
    step();
    checkOutput("hold_rvalid_clr", {31'd0, dbg_rvalid}, 32'd0);

    // Lock: set by a locked core access, cleared only by an unlocked one.
    applyStimulus(1'b1, 1'b0, 30'd6, 4'hF, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    driveDbg(1'b1, 1'b0, 30'd6, 4'hF, 32'd0);
    #1;
    checkOutput("lock_gnt_0", {31'd0, dbg_gnt}, 32'd0);
    step();
    step();
    checkOutput("lock_gnt_1", {31'd0, dbg_gnt}, 32'd0);
    checkOutput("lock_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 30'd5, 4'hF, 32'd0);
    #1;
    checkOutput("unlock_gnt_core", {31'd0, dbg_gnt}, 32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 30'd0, 4'h0, 32'd0);
    #1;
    checkOutput("buslock_gnt", {31'd0, dbg_gnt}, 32'd0);
    bus_lock = 1'b0;
    #1;
    checkOutput("unlock_gnt", {31'd0, dbg_gnt}, 32'd1);
    step();
    driveDbg(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
    checkOutput("unlock_rdata", dbg_rdata, 32'h1122AA44);
    checkOutput("unlock_data_in", data_in, 32'hDEADBEEF);

    // Unmapped addresses read 0 and must not alias onto RAM.
    coreOp(1'b1, 30'd0, 4'hF, 32'h0BADF00D);
    coreOp(1'b1, 30'd4096, 4'hF, 32'h55555555);
    coreOp(1'b0, 30'd4096, 4'hF, 32'd0);
    checkOutput("unmapped_rd", data_in, 32'd0);
    coreOp(1'b0, 30'd0, 4'hF, 32'd0);
    checkOutput("no_alias", data_in, 32'h0BADF00D);

`ifdef DATA_MEM_TIMER_EN
    coreOp(1'b1, 30'h3FFFFFFE, 4'hF, 32'd10);
    coreOp(1'b1, 30'h3FFFFFFF, 4'hF, 32'd0);
    coreOp(1'b1, 30'h3FFFFFFD, 4'hF, 32'd0);
    coreOp(1'b1, 30'h3FFFFFFC, 4'hF, 32'd0);
    repeat (10) step();
    checkOutput("irq_before", {31'd0, timer_irq}, 32'd0);
    step();
    checkOutput("irq_rise", {31'd0, timer_irq}, 32'd1);
    coreOp(1'b0, 30'h3FFFFFFE, 4'hF, 32'd0);
    checkOutput("mtimecmp_lo", data_in, 32'd10);
    coreOp(1'b1, 30'h3FFFFFFD, 4'hF, 32'hFFFFFFFF);
    coreOp(1'b1, 30'h3FFFFFFC, 4'hF, 32'hFFFFFFFF);
    coreOp(1'b0, 30'h3FFFFFFC, 4'hF, 32'd0);
    checkOutput("mtime_max", data_in, 32'hFFFFFFFF);
    coreOp(1'b0, 30'h3FFFFFFC, 4'hF, 32'd0);
    checkOutput("mtime_wrap_lo", data_in, 32'd0);
    coreOp(1'b0, 30'h3FFFFFFD, 4'hF, 32'd0);
    checkOutput("mtime_wrap_hi", data_in, 32'd0);
`else
    coreOp(1'b1, 30'h3FFFFFFE, 4'hF, 32'd0);
    coreOp(1'b0, 30'h3FFFFFFC, 4'hF, 32'd0);
    checkOutput("mmio_off_rd", data_in, 32'd0);
    step();
    checkOutput("mmio_off_irq", {31'd0, timer_irq}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
